// File: rtl/sram_array.sv
// sram_array: one-read / one-write synchronous RAM with per-lane write
// strobes. Read data is registered, with a fixed latency of READ_LATENCY
// clock edges.
//
// Ports:
//   clk          clock; everything samples on the rising edge
//   reset_n      async active-low reset; clears the read pipeline only
//   readAddr     read entry index, sampled every edge
//   readData     registered read data
//   writeAddr    write entry index
//   writeData    write data; lane i = bits [i*WORDSIZE +: WORDSIZE]
//   writeEnable  per-lane write strobe
//
// Build option: SRAM_WRITE_FORWARD_EN selects write-first behaviour on a
// same-address read/write. Without it the RAM is read-first.
module sram_array #(
  parameter  int WIDTH        = 512,
  parameter  int LOGDEPTH     = 9,
  parameter  int WORDSIZE     = 64,
  parameter  int READ_LATENCY = 1,
  localparam int LANES        = WIDTH / WORDSIZE,
  localparam int DEPTH        = 2 ** LOGDEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [LOGDEPTH-1:0] readAddr,
  output logic [WIDTH-1:0]    readData,
  input  logic [LOGDEPTH-1:0] writeAddr,
  input  logic [WIDTH-1:0]    writeData,
  input  logic [LANES-1:0]    writeEnable
);

  if (WIDTH % WORDSIZE != 0) begin : g_bad_width
    $error("sram_array: WIDTH must be a multiple of WORDSIZE");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("sram_array: READ_LATENCY must be in 1..4");
  end

  logic [WIDTH-1:0]                     mem [DEPTH];
  logic [WIDTH-1:0]                     rd_d;
  logic [READ_LATENCY-1:0][WIDTH-1:0]   pipe_q;

  // Array word as seen by a read sampled this edge. The array itself still
  // holds the pre-write value, so the default is read-first.
  always_comb begin
    rd_d = mem[readAddr];
`ifdef SRAM_WRITE_FORWARD_EN
    for (int i = 0; i < LANES; i++)
      if (writeEnable[i] && (writeAddr == readAddr))
        rd_d[i*WORDSIZE +: WORDSIZE] = writeData[i*WORDSIZE +: WORDSIZE];
`endif
  end

  // The array is written only out of reset and is never cleared. Sharing the
  // async-reset process keeps the write suppressed for as long as reset_n is
  // low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (writeEnable[i])
          mem[writeAddr][i*WORDSIZE +: WORDSIZE] <= writeData[i*WORDSIZE +: WORDSIZE];
      pipe_q[0] <= rd_d;
      for (int k = 1; k < READ_LATENCY; k++)
        pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign readData = pipe_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_array.sv
module tb_sram_array;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [8:0]   rd_addr, wr_addr;
  logic [511:0] wr_data, rd_data, rd_data3;
  logic [7:0]   we;

  logic [8:0]   t_raddr, t_waddr;
  logic [51:0]  t_wdata, t_rdata;
  logic [0:0]   t_we;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_array #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .readAddr(rd_addr), .readData(rd_data),
    .writeAddr(wr_addr), .writeData(wr_data), .writeEnable(we));

  sram_array #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64), .READ_LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .readAddr(rd_addr), .readData(rd_data3),
    .writeAddr(wr_addr), .writeData(wr_data), .writeEnable(we));

  sram_array #(.WIDTH(52), .LOGDEPTH(9), .WORDSIZE(52), .READ_LATENCY(1)) u_tag (
    .clk(clk), .reset_n(reset_n), .readAddr(t_raddr), .readData(t_rdata),
    .writeAddr(t_waddr), .writeData(t_wdata), .writeEnable(t_we));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [511:0] PAT_AA = {64{8'hAA}};
  localparam logic [511:0] PAT_55 = {64{8'h55}};
  localparam logic [511:0] PAT_2  = {
    64'h0123_4567_89AB_CDE7, 64'h0123_4567_89AB_CDE6,
    64'h0123_4567_89AB_CDE5, 64'h0123_4567_89AB_CDE4,
    64'h0123_4567_89AB_CDE3, 64'h0123_4567_89AB_CDE2,
    64'h0123_4567_89AB_CDE1, 64'h0123_4567_89AB_CDE0};
  localparam logic [511:0] ONES   = {512{1'b1}};
  localparam logic [511:0] PART_3 = {
    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
  localparam logic [511:0] P11    = {8{64'h1111_1111_1111_1111}};
  localparam logic [511:0] P22    = {8{64'h2222_2222_2222_2222}};

  initial begin
    reset_n = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; we = '0;
    t_raddr = '0; t_waddr = '0; t_wdata = '0; t_we = '0;

    // reset state
    #12;
    chk("reset_rd", rd_data, '0);
    chk("reset_rd3", rd_data3, '0);
    reset_n = 1'b1;

    // 1: write 5, read it, then assert reset mid-cycle
    wr_addr = 9'd5; wr_data = PAT_AA; we = 8'hFF;
    step();
    we = '0; rd_addr = 9'd5;
    step();
    chk("t1_pre_reset", rd_data, PAT_AA);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_async_clear", rd_data, '0);
    chk("t1_async_clear3", rd_data3, '0);
    // a write presented while in reset must be suppressed
    wr_addr = 9'd5; wr_data = PAT_55; we = 8'hFF;
    step();
    chk("t1_held_reset", rd_data, '0);
    we = '0;
    reset_n = 1'b1;
    step();
    chk("t1_array_kept", rd_data, PAT_AA);

    // 2: full-line write/read on both latencies
    wr_addr = 9'd3; wr_data = PAT_2; we = 8'hFF;
    step();
    we = '0; rd_addr = 9'd3;
    step();
    chk("t2_full_rd", rd_data, PAT_2);
    step();
    step();
    chk("t2_full_rd_lat3", rd_data3, PAT_2);

    // 3: partial-lane write
    wr_addr = 9'd7; wr_data = ONES; we = 8'hFF;
    step();
    wr_data = '0; we = 8'b0000_0101;
    step();
    we = '0; rd_addr = 9'd7;
    step();
    chk("t3_partial", rd_data, PART_3);

    // 4: read-during-write at the same address
    wr_addr = 9'd10; wr_data = P11; we = 8'hFF;
    step();
    rd_addr = 9'd10; wr_data = P22; we = 8'hFF;
    step();
`ifdef SRAM_WRITE_FORWARD_EN
    chk("t4_rdw", rd_data, P22);
`else
    chk("t4_rdw", rd_data, P11);
`endif
    we = '0;
    step();
    chk("t4_after", rd_data, P22);

    // 5: fill with own index, then stream reads back-to-back
    for (int i = 0; i < 512; i++) begin
      wr_addr = 9'(i); wr_data = 512'(i); we = 8'hFF;
      step();
    end
    we = '0;
    for (int i = 0; i < 512; i++) begin
      rd_addr = 9'(i);
      step();
      chk($sformatf("t5_seq%0d", i), rd_data, 512'(i));
      if (i >= 2) chk($sformatf("t5_seq3_%0d", i), rd_data3, 512'(i - 2));
    end

    // 6: tag configuration, single lane
    t_waddr = 9'd0; t_wdata = 52'hA_BCDE; t_we = 1'b1;
    step();
    t_waddr = 9'd511; t_wdata = 52'h1_2345;
    step();
    t_raddr = 9'd511; t_waddr = 9'd0; t_wdata = 52'hF_FFFF; t_we = 1'b0;
    step();
    chk("t6_tag_511", 512'(t_rdata), 512'(52'h1_2345));
    t_raddr = 9'd0;
    step();
    chk("t6_tag_no_we", 512'(t_rdata), 512'(52'hA_BCDE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
